// File: rtl/sci_pkg.sv
// Shared definitions for the serial configuration interface (SCI) blocks:
// receive FSM encoding, default word width and a counter-width helper.
package sci_pkg;

   typedef enum logic {
      SCI_RX_IDLE  = 1'b0,
      SCI_RX_SHIFT = 1'b1
   } sci_rx_state_e;

   localparam int SCI_DATA_WIDTH = 8;

   // Bits needed to count 0..value-1; never less than 1.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sci_rx_shift.sv
// SCI receive shift register and bit counter. Bits enter at the MSB and move
// toward the LSB, so the first bit of a word ends up in bit 0.
module sci_rx_shift
   import sci_pkg::*;
#(
   parameter int DATA_WIDTH = SCI_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  CLR,
   input  logic                  EN,
   input  logic                  SIN,
   output logic [DATA_WIDTH-1:0] PDATA,
   output logic                  LAST
);

   localparam int CW = clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] base_sh;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         base_cnt;

   // PDATA is the word including the bit presented this cycle, so the
   // consumer can capture a completed word on the same edge that shifts it.
   // NOTE: every always_comb output gets a value on every path to avoid latches.
   always_comb begin
      base_sh  = CLR ? '0 : shreg;
      base_cnt = CLR ? '0 : cnt;
      PDATA    = {SIN, base_sh[DATA_WIDTH-1:1]};
      LAST     = EN && (base_cnt == CNT_LAST);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (EN) begin
         shreg <= PDATA;
         cnt   <= LAST ? '0 : base_cnt + 1'b1;
      end else if (CLR) begin
         shreg <= '0;
         cnt   <= '0;
      end
   end

endmodule

// File: rtl/sci_rx_framer.sv
// SCI receive framer: qualifies serial bits with CSN, assembles LSB-first words
// and presents them on a valid/ready output with sticky short/overrun flags.
module sci_rx_framer
   import sci_pkg::*;
#(
   parameter int DATA_WIDTH = SCI_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  CSN,
   input  logic                  SI_VALID,
   input  logic                  SI_DATA,
   output logic [DATA_WIDTH-1:0] DOUT,
   output logic                  DOUT_VALID,
   input  logic                  DOUT_READY,
   output logic                  BUSY,
   output logic                  ERR_SHORT,
   output logic                  ERR_OVR,
   input  logic                  ERR_CLR
);

   sci_rx_state_e         state;
   logic                  partial;
   logic                  bit_en;
   logic                  shift_clr;
   logic                  last;
   logic [DATA_WIDTH-1:0] pdata;
   logic                  short_set;
   logic                  ovr_set;
   logic                  load;

   assign bit_en    = SI_VALID && !CSN;
   assign shift_clr = (state == SCI_RX_IDLE) || CSN;
   assign short_set = (state == SCI_RX_SHIFT) && CSN && partial;
   assign load      = last && (!DOUT_VALID || DOUT_READY);
   assign ovr_set   = last && DOUT_VALID && !DOUT_READY;

   sci_rx_shift #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shift (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .CLR   (shift_clr),
      .EN    (bit_en),
      .SIN   (SI_DATA),
      .PDATA (pdata),
      .LAST  (last)
   );

   // partial tracks "some bits of the current word already accepted", which
   // is what decides a short frame when CSN rises.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state   <= SCI_RX_IDLE;
         BUSY    <= 1'b0;
         partial <= 1'b0;
      end else begin
         case (state)
            SCI_RX_IDLE: begin
               if (!CSN) begin
                  state   <= SCI_RX_SHIFT;
                  BUSY    <= 1'b1;
                  partial <= bit_en;
               end
            end
            SCI_RX_SHIFT: begin
               if (CSN) begin
                  state   <= SCI_RX_IDLE;
                  BUSY    <= 1'b0;
                  partial <= 1'b0;
               end else if (bit_en) begin
                  partial <= !last;
               end
            end
            default: begin
               state   <= SCI_RX_IDLE;
               BUSY    <= 1'b0;
               partial <= 1'b0;
            end
         endcase
      end
   end

   // A refill in the accept cycle keeps DOUT_VALID high with the new word.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         DOUT       <= '0;
         DOUT_VALID <= 1'b0;
      end else if (load) begin
         DOUT       <= pdata;
         DOUT_VALID <= 1'b1;
      end else if (DOUT_VALID && DOUT_READY) begin
         DOUT_VALID <= 1'b0;
      end
   end

   // Set has priority over a coincident clear.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         ERR_SHORT <= 1'b0;
         ERR_OVR   <= 1'b0;
      end else begin
         if (short_set)    ERR_SHORT <= 1'b1;
         else if (ERR_CLR) ERR_SHORT <= 1'b0;
         if (ovr_set)      ERR_OVR   <= 1'b1;
         else if (ERR_CLR) ERR_OVR   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sci_rx_framer.sv
// Self-checking bench for sci_rx_framer: directed scenarios plus randomized
// frames, every cycle compared against a word-level reference model.
module tb_sci_rx_framer;

   localparam int W = 8;

   logic         CLK        = 1'b0;
   logic         RSTN       = 1'b0;
   logic         CSN        = 1'b1;
   logic         SI_VALID   = 1'b0;
   logic         SI_DATA    = 1'b0;
   logic         DOUT_READY = 1'b0;
   logic         ERR_CLR    = 1'b0;
   logic [W-1:0] DOUT;
   logic         DOUT_VALID;
   logic         BUSY;
   logic         ERR_SHORT;
   logic         ERR_OVR;

   sci_rx_framer #(
      .DATA_WIDTH (W)
   ) dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .CSN        (CSN),
      .SI_VALID   (SI_VALID),
      .SI_DATA    (SI_DATA),
      .DOUT       (DOUT),
      .DOUT_VALID (DOUT_VALID),
      .DOUT_READY (DOUT_READY),
      .BUSY       (BUSY),
      .ERR_SHORT  (ERR_SHORT),
      .ERR_OVR    (ERR_OVR),
      .ERR_CLR    (ERR_CLR)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
      n_checks++;
      if (got === expected) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expected, $time);
   endtask

   // Reference model: a frame is a run of CSN-low cycles; bits are summed
   // into a word by weight 2**position, and a word is emitted after W bits.
   bit m_in_frame;
   int m_nbits;
   int m_acc;
   int m_dout;
   bit m_valid;
   bit m_short;
   bit m_ovr;

   function automatic void model_reset();
      m_in_frame = 0;
      m_nbits    = 0;
      m_acc      = 0;
      m_dout     = 0;
      m_valid    = 0;
      m_short    = 0;
      m_ovr      = 0;
   endfunction

   function automatic void model_step(input bit csn, input bit siv, input bit sid,
                                      input bit rdy, input bit clr);
      bit short_set = 0;
      bit ovr_set   = 0;
      bit done      = 0;
      int word      = 0;
      if (!csn) begin
         m_in_frame = 1;
         if (siv) begin
            m_acc = m_acc + (int'(sid) << m_nbits);
            m_nbits++;
            if (m_nbits == W) begin
               done    = 1;
               word    = m_acc;
               m_acc   = 0;
               m_nbits = 0;
            end
         end
      end else begin
         if (m_nbits != 0) short_set = 1;
         m_in_frame = 0;
         m_nbits    = 0;
         m_acc      = 0;
      end
      if (done && (!m_valid || rdy)) begin
         m_dout  = word;
         m_valid = 1;
      end else begin
         if (done) ovr_set = 1;
         if (m_valid && rdy) m_valid = 0;
      end
      m_short = short_set || (m_short && !clr);
      m_ovr   = ovr_set || (m_ovr && !clr);
   endfunction

   task automatic compare_all();
      check("dout",       32'(DOUT),       32'(m_dout));
      check("dout_valid", 32'(DOUT_VALID), 32'(m_valid));
      check("busy",       32'(BUSY),       32'(m_in_frame));
      check("err_short",  32'(ERR_SHORT),  32'(m_short));
      check("err_ovr",    32'(ERR_OVR),    32'(m_ovr));
   endtask

   // One clock: drive inputs away from the edge, step the model, sample at +1.
   task automatic cycle(input logic csn, input logic siv, input logic sid,
                        input logic rdy, input logic clr);
      CSN        = csn;
      SI_VALID   = siv;
      SI_DATA    = sid;
      DOUT_READY = rdy;
      ERR_CLR    = clr;
      @(posedge CLK);
      model_step(csn, siv, sid, rdy, clr);
      #1;
      compare_all();
   endtask

   task automatic send_bits(input int value, input int nbits, input logic rdy);
      for (int i = 0; i < nbits; i++) cycle(1'b0, 1'b1, value[i], rdy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #12;
      compare_all();
      @(negedge CLK);
      RSTN = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Single frame, consumer always ready.
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t2_busy_in_frame", 32'(BUSY), 32'd1);
      send_bits('h5A, W, 1'b1);
      check("t2_dout", 32'(DOUT), 32'h5A);
      check("t2_valid", 32'(DOUT_VALID), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t2_valid_cleared", 32'(DOUT_VALID), 32'd0);
      check("t2_busy_idle", 32'(BUSY), 32'd0);

      // Back-to-back words with the consumer stalled: second word is lost.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_bits('h3C, W, 1'b0);
      send_bits('hA5, W, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t3_dout_kept", 32'(DOUT), 32'h3C);
      check("t3_err_ovr", 32'(ERR_OVR), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t3_valid_dropped", 32'(DOUT_VALID), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t3_ovr_cleared", 32'(ERR_OVR), 32'd0);
      check("t3_no_a5", 32'(DOUT), 32'h3C);

      // Accept-and-refill on the completing bit of the second word.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_bits('h3C, W, 1'b0);
      send_bits('hC3, W - 1, 1'b0);
      check("t4_first_word", 32'(DOUT), 32'h3C);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("t4_refill_dout", 32'(DOUT), 32'hC3);
      check("t4_refill_valid", 32'(DOUT_VALID), 32'd1);
      check("t4_no_ovr", 32'(ERR_OVR), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

      // Short frame, recovery, clear, and clear coincident with a new short.
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_bits('h15, 5, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t5_err_short", 32'(ERR_SHORT), 32'd1);
      check("t5_no_word", 32'(DOUT_VALID), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_bits('hFF, W, 1'b0);
      check("t5_full_after_short", 32'(DOUT), 32'hFF);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_short_cleared", 32'(ERR_SHORT), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_bits('h06, 3, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("t5_set_beats_clr", 32'(ERR_SHORT), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Bits strobed while deselected are ignored.
      for (int i = 0; i < W; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_bits('h01, W, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t6_dout", 32'(DOUT), 32'h01);
      check("t6_no_errors", 32'({ERR_SHORT, ERR_OVR}), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a word with state to discard.
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_bits('h02, 2, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_bits('h77, W, 1'b0);
      send_bits('h05, 3, 1'b0);
      check("t7_pre_reset_valid", 32'(DOUT_VALID), 32'd1);
      #2;
      RSTN     = 1'b0;
      CSN      = 1'b1;
      SI_VALID = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("t7_async_outputs", 32'({DOUT, DOUT_VALID, BUSY, ERR_SHORT, ERR_OVR}), 32'd0);
      @(negedge CLK);
      RSTN = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_bits('h5A, W, 1'b1);
      check("t7_frame_after_reset", 32'(DOUT), 32'h5A);
      check("t7_no_short", 32'(ERR_SHORT), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

      // Randomized frames of assorted lengths with random back-pressure.
      for (int f = 0; f < 200; f++) begin
         int target;
         int got_bits;
         logic siv;
         case ($urandom_range(0, 3))
            0:       target = W;
            1:       target = 2 * W;
            2:       target = $urandom_range(1, 3 * W);
            default: target = 3 * W;
         endcase
         repeat ($urandom_range(0, 2))
            cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
         got_bits = 0;
         while (got_bits < target) begin
            siv = 1'($urandom_range(0, 3) != 0);
            cycle(1'b0, siv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0));
            if (siv) got_bits++;
         end
      end
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sci_rx_framer.md
Name: sci_rx_framer

Overview:
- Serial-configuration-interface receive framer; sits directly upstream of the SCI parallel register/command decoder.
- Qualifies serial bits with a frame select and accumulates them LSB-first into DATA_WIDTH-bit words.
- Hands each completed word out over a valid/ready handshake.
- Flags malformed frames (short frame) and back-pressure loss (overrun).

Parameters:
- DATA_WIDTH, 8, word length in bits; must be >= 2.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- CSN  input  1  frame select, active low, already synchronised to CLK.
- SI_VALID  input  1  one-cycle strobe: SI_DATA holds a new serial bit.
- SI_DATA  input  1  serial data bit.
- DOUT  output  DATA_WIDTH  completed word.
- DOUT_VALID  output  1  DOUT holds an unconsumed word.
- DOUT_READY  input  1  consumer accepts DOUT when high together with DOUT_VALID.
- BUSY  output  1  high while state is SHIFT.
- ERR_SHORT  output  1  sticky: frame ended mid-word.
- ERR_OVR  output  1  sticky: word dropped because the output was still full.
- ERR_CLR  input  1  one-cycle pulse that clears both sticky errors.

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE, bit counter 0, shift register 0, DOUT 0, DOUT_VALID 0, BUSY 0, ERR_SHORT 0, ERR_OVR 0.
- A bit is accepted only in a cycle where SI_VALID=1 and CSN=0. Bits with CSN=1 are ignored in every state.
- Shift register fills LSB-first: shreg <= {SI_DATA, shreg[DATA_WIDTH-1:1]}. The first accepted bit of a word ends up in DOUT[0].
- Bit counter width: clog2(DATA_WIDTH). It increments per accepted bit and wraps to 0 after the DATA_WIDTH-th bit.
- FSM IDLE: CSN=0 moves to SHIFT with counter cleared.
  - If SI_VALID is also high in that cycle, the bit is accepted and counts as bit 0.
- FSM SHIFT: accepts bits as above. CSN=1 returns to IDLE.
  - If the counter is nonzero when CSN rises, set ERR_SHORT and discard the partial word (counter cleared).
  - Multiple back-to-back words per frame are allowed.
- Word completion: the accepted bit is the DATA_WIDTH-th bit of the word.
  - The full word, including this bit, is loaded into DOUT the next cycle, and DOUT_VALID is set — latency 1 cycle after the last bit.
  - Load is allowed if DOUT_VALID=0, or if DOUT_VALID=1 and DOUT_READY=1 in the same cycle (accept and refill; DOUT_VALID stays 1).
  - Otherwise the word is dropped, DOUT is unchanged, and ERR_OVR is set.
- Handshake: DOUT and DOUT_VALID stay stable until DOUT_READY=1 while DOUT_VALID=1. The following cycle DOUT_VALID=0, unless a refill happened in that cycle. DOUT holds its last value when not valid.
- Errors are sticky until ERR_CLR. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-frame aborts everything. No error is flagged after reset.
- BUSY is a registered decode of state == SHIFT.

Decomposition:
- Shared package sci_pkg holds:
  - state encodings SCI_RX_IDLE=1'b0, SCI_RX_SHIFT=1'b1;
  - default SCI_DATA_WIDTH=8;
  - counter-width function clog2.
- One natural sub-module, sci_rx_shift. It contains the shift register plus bit counter with ports CLK, RSTN, CLR, EN, SIN, and outputs PDATA and LAST. The top level keeps the FSM, the output register/handshake and the error flags.

Test Plan:
- Reset mid-word: drive 3 bits, pulse RSTN low -> all outputs 0 immediately. Next frame of 8 bits 0x5A -> DOUT=0x5A, ERR_SHORT=0.
- Single frame, DOUT_READY=1: CSN low, bits 0,1,0,1,1,0,1,0 LSB-first -> DOUT=0x5A, DOUT_VALID=1 exactly one cycle after the 8th SI_VALID, then cleared after the accept cycle; BUSY high only while CSN=0.
- Back-to-back words, DOUT_READY held 0: send 0x3C then 0xA5 in one frame -> DOUT stays 0x3C, ERR_OVR=1. Then DOUT_READY=1 -> DOUT_VALID drops, no 0xA5 appears.
- Accept-and-refill: consumer asserts DOUT_READY in the same cycle the second word 0xC3 completes -> DOUT goes 0x3C to 0xC3 with DOUT_VALID continuously 1, ERR_OVR=0.
- Short frame: CSN low, 5 bits, CSN high -> ERR_SHORT=1, DOUT_VALID=0. Next full frame 0xFF -> DOUT=0xFF with the counter restarted. ERR_CLR pulse -> ERR_SHORT=0. ERR_CLR coincident with a new short frame -> ERR_SHORT stays 1.
- Ignored bits: SI_VALID pulses with CSN=1 (0xFF pattern), then a frame 0x01 -> DOUT=0x01, no extra words, no errors.
